perf_event_counter: RTL and testbench
=====================================

# perf_event_counter

Synthesizable performance-monitor block for the pipelined CPU. It counts per-channel pipeline events (stall, flush, branch, retire, …) and total run cycles while enabled. Counters can be frozen into a snapshot bank and read back over a simple registered read port. An optional cycle limit halts counting, so run-length measurements are made in hardware. It sits beside the CPU top level, with event lines driven from the hazard-detection and control outputs.

## Interface
- N_CH, 4: number of event channels.
- WIDTH, 32: width of every counter, including the cycle counter.
- SEL_W, 3: read-select width; 2^SEL_W must be greater than N_CH.
- SATURATE, 0: 0 = counters wrap on overflow; 1 = counters hold at all-ones.
- LIMIT, 0: number of RUN cycles before automatic halt; 0 = no limit.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level; 1 = run or resume, 0 = pause.
- clear_i  in  1  synchronous clear of all counters, snapshots, flags and state.
- event_i  in  N_CH  per-channel event strobes, sampled each edge.
- snap_i  in  1  copy live counters into the snapshot bank.
- rd_en_i  in  1  read request.
- rd_sel_i  in  SEL_W  read index: 0..N_CH-1 selects a channel; N_CH selects the cycle counter; above N_CH returns 0.
- rd_snap_i  in  1  0 = read live bank; 1 = read snapshot bank.
- rd_data_o  out  WIDTH  registered read data.
- rd_valid_o  out  1  one-cycle pulse when rd_data_o is updated.
- ovf_o  out  N_CH  sticky per-channel overflow flags.
- cycle_o  out  WIDTH  live cycle counter.
- state_o  out  2  current state: IDLE=00, RUN=01, HALT=10.
- halt_o  out  1  1 while in HALT.

## Operation
- State transitions:
  - IDLE→RUN when start_i=1.
  - RUN→IDLE when start_i=0. Counts are retained.
  - RUN→HALT on the edge where the cycle counter increments to LIMIT, only when LIMIT≠0.
  - HALT→IDLE only on clear_i; start_i is ignored in HALT.
- Counting in RUN, each edge:
  - cycle counter +1;
  - channel i +1 when event_i[i]=1.
- Events arriving in IDLE or HALT are ignored.
- The transition edge into HALT still counts that cycle's events.
- Overflow (counter all-ones and incrementing):
  - SATURATE=0: wrap to 0.
  - SATURATE=1: hold at all-ones.
  - Either mode sets ovf_o[i]. Cycle-counter overflow follows the same rule but has no flag.
- Snapshot: snap_i copies the pre-edge live values (channels and cycle counter) into the snapshot bank atomically. Live counting on that edge proceeds normally.
- Read: rd_en_i registers the pre-edge value of the selected bank and index into rd_data_o. rd_data_o holds its value between reads.
- Priority, highest first: rst_i, clear_i, then everything else. clear_i zeros live counters, snapshots and ovf_o, and forces IDLE. A read on the clear edge returns the pre-clear value.

## Timing
- Reset values: state IDLE; every counter, snapshot, ovf_o, rd_data_o, rd_valid_o, halt_o and cycle_o = 0.
- Reset is asynchronous: outputs go to their reset values without waiting for a clock edge.
- start_i takes effect at the next edge. The first counted cycle is the edge where state moves IDLE→RUN; that edge increments the cycle counter to 1.
- Read latency: one cycle. rd_en_i sampled at edge N gives rd_data_o and rd_valid_o=1 after edge N. rd_valid_o falls after edge N+1 unless rd_en_i is held.
- Back-to-back reads allowed, one per cycle.
- halt_o, state_o, cycle_o and ovf_o are registered outputs, updated at the same edge as the counters.
- Width rule: all arithmetic is modulo 2^WIDTH; no carry is visible outside ovf_o.

## Test plan
- Basic count: reset, start_i=1 for 10 cycles, event_i[0]=1 all 10 cycles, event_i[1] pulsed 3 times, then start_i=0 → channel 0 = 10, channel 1 = 3, cycle_o = 10, state IDLE; after 5 paused cycles with events, values unchanged.
- Limit halt: LIMIT=30, start_i held high → halt_o=1 after the 30th RUN edge, cycle_o=30. Further events and start_i toggling change nothing. clear_i → IDLE with all counters = 0.
- Overflow: WIDTH=4, 17 events on channel 2:
  - SATURATE=0 → value 1 and ovf_o[2]=1;
  - SATURATE=1 → value 15 and ovf_o[2]=1;
  - ovf_o[0]=0 in both cases.
- Snapshot and read: snap_i after 7 counted events on channel 0, then 5 more events. rd_snap_i=1, rd_sel_i=0 → 7 one cycle later, rd_valid_o pulses once. rd_snap_i=0 → 12. rd_sel_i=N_CH → live cycle count. rd_sel_i=7 → 0.
- Simultaneous events: clear_i, snap_i and event_i all high on one edge → every live and snapshot value = 0, ovf_o=0, state IDLE.
- Async reset mid-run: assert rst_i between edges during RUN → all outputs 0 immediately. After release, counting resumes from 0 when start_i=1.

Source files
------------

// File: rtl/perf_event_counter_if.sv
// Control, event and read-port bundle of the performance counter block.
// master = the block driving commands/events, slave = perf_event_counter.
interface perf_event_counter_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);
  logic              start_i;
  logic              clear_i;
  logic [N_CH-1:0]   event_i;
  logic              snap_i;
  logic              rd_en_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic              rd_snap_i;
  logic [WIDTH-1:0]  rd_data_o;
  logic              rd_valid_o;
  logic [N_CH-1:0]   ovf_o;
  logic [WIDTH-1:0]  cycle_o;
  logic [1:0]        state_o;
  logic              halt_o;

  // Read handshake: rd_en_i is a request with no backpressure (always accepted);
  // rd_valid_o pulses for exactly one cycle after each accepted request and
  // rd_data_o holds its value until the next accepted request.
  modport master (
    output start_i, clear_i, event_i, snap_i, rd_en_i, rd_sel_i, rd_snap_i,
    input  rd_data_o, rd_valid_o, ovf_o, cycle_o, state_o, halt_o
  );

  modport slave (
    input  start_i, clear_i, event_i, snap_i, rd_en_i, rd_sel_i, rd_snap_i,
    output rd_data_o, rd_valid_o, ovf_o, cycle_o, state_o, halt_o
  );
endinterface

// File: rtl/perf_event_counter.sv
// Per-channel pipeline event counters plus a run-cycle counter, with a
// snapshot bank, registered read port and optional cycle-limit halt.
module perf_event_counter #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 32,
  parameter int SEL_W    = 3,
  parameter int SATURATE = 0,
  parameter int LIMIT    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  perf_event_counter_if.slave  bus
);

  localparam logic [1:0]       S_IDLE   = 2'b00;
  localparam logic [1:0]       S_RUN    = 2'b01;
  localparam logic [1:0]       S_HALT   = 2'b10;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH:0]   LIMIT_W  = (WIDTH+1)'(LIMIT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q  [N_CH];
  logic [WIDTH-1:0] cnt_d  [N_CH];
  logic [WIDTH-1:0] snap_q [N_CH];
  logic [WIDTH-1:0] cyc_q, cyc_d, snap_cyc_q;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data_q, rd_mux;
  logic             rd_valid_q;
  logic             count_en, limit_hit;

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
    if (v == ALL_ONES) return (SATURATE != 0) ? ALL_ONES : '0;
    return v + WIDTH'(1);
  endfunction

  // The IDLE->RUN edge is itself a counted cycle, so counting keys off start_i.
  always_comb begin
    count_en = bus.start_i && (state_q != S_HALT);
    cyc_d    = cyc_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < N_CH; i++) cnt_d[i] = cnt_q[i];
    if (count_en) begin
      cyc_d = bump(cyc_q);
      for (int i = 0; i < N_CH; i++) begin
        if (bus.event_i[i]) begin
          cnt_d[i] = bump(cnt_q[i]);
          if (cnt_q[i] == ALL_ONES) ovf_d[i] = 1'b1;
        end
      end
    end
    limit_hit = count_en && (LIMIT != 0) && ({1'b0, cyc_d} == LIMIT_W);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (limit_hit)        state_d = S_HALT;
        else if (bus.start_i) state_d = S_RUN;
        else                  state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.rd_sel_i == SEL_W'(i)) rd_mux = bus.rd_snap_i ? snap_q[i] : cnt_q[i];
    end
    if (bus.rd_sel_i == SEL_W'(N_CH)) rd_mux = bus.rd_snap_i ? snap_cyc_q : cyc_q;
  end

  // The read path sits outside the clear branch so a read on a clear edge sees pre-clear data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      snap_cyc_q <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= rd_mux;
      if (bus.clear_i) begin
        state_q    <= S_IDLE;
        cyc_q      <= '0;
        snap_cyc_q <= '0;
        ovf_q      <= '0;
        for (int i = 0; i < N_CH; i++) begin
          cnt_q[i]  <= '0;
          snap_q[i] <= '0;
        end
      end else begin
        state_q <= state_d;
        cyc_q   <= cyc_d;
        ovf_q   <= ovf_d;
        for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        if (bus.snap_i) begin
          snap_cyc_q <= cyc_q;
          for (int i = 0; i < N_CH; i++) snap_q[i] <= cnt_q[i];
        end
      end
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.cycle_o    = cyc_q;
  assign bus.state_o    = state_q;
  assign bus.halt_o     = (state_q == S_HALT);

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: four configurations driven in lockstep and
// checked every cycle against an arithmetic model, plus directed sequences.
module tb_perf_event_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 0, clear = 0, snap = 0, rd_en = 0, rd_snap = 0;
  logic [3:0] ev = '0;
  logic [2:0] rd_sel = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: defaults, dut1: LIMIT=30, dut2: 4-bit wrap, dut3: 4-bit saturate
  perf_event_counter_if #(.N_CH(4), .WIDTH(32), .SEL_W(3)) if0 ();
  perf_event_counter_if #(.N_CH(4), .WIDTH(32), .SEL_W(3)) if1 ();
  perf_event_counter_if #(.N_CH(4), .WIDTH(4),  .SEL_W(3)) if2 ();
  perf_event_counter_if #(.N_CH(4), .WIDTH(4),  .SEL_W(3)) if3 ();

  perf_event_counter #(.N_CH(4), .WIDTH(32), .SEL_W(3), .SATURATE(0), .LIMIT(0))
    u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  perf_event_counter #(.N_CH(4), .WIDTH(32), .SEL_W(3), .SATURATE(0), .LIMIT(30))
    u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  perf_event_counter #(.N_CH(4), .WIDTH(4), .SEL_W(3), .SATURATE(0), .LIMIT(0))
    u2 (.clk_i(clk), .rst_i(rst), .bus(if2));
  perf_event_counter #(.N_CH(4), .WIDTH(4), .SEL_W(3), .SATURATE(1), .LIMIT(0))
    u3 (.clk_i(clk), .rst_i(rst), .bus(if3));

  assign if0.start_i = start; assign if0.clear_i = clear; assign if0.event_i = ev;
  assign if0.snap_i = snap; assign if0.rd_en_i = rd_en; assign if0.rd_sel_i = rd_sel;
  assign if0.rd_snap_i = rd_snap;
  assign if1.start_i = start; assign if1.clear_i = clear; assign if1.event_i = ev;
  assign if1.snap_i = snap; assign if1.rd_en_i = rd_en; assign if1.rd_sel_i = rd_sel;
  assign if1.rd_snap_i = rd_snap;
  assign if2.start_i = start; assign if2.clear_i = clear; assign if2.event_i = ev;
  assign if2.snap_i = snap; assign if2.rd_en_i = rd_en; assign if2.rd_sel_i = rd_sel;
  assign if2.rd_snap_i = rd_snap;
  assign if3.start_i = start; assign if3.clear_i = clear; assign if3.event_i = ev;
  assign if3.snap_i = snap; assign if3.rd_en_i = rd_en; assign if3.rd_sel_i = rd_sel;
  assign if3.rd_snap_i = rd_snap;

  logic [31:0] g_rd  [4];
  logic [31:0] g_cyc [4];
  logic [3:0]  g_ovf [4];
  logic [1:0]  g_st  [4];
  logic        g_halt[4];
  logic        g_val [4];

  assign g_rd[0] = if0.rd_data_o;         assign g_rd[1] = if1.rd_data_o;
  assign g_rd[2] = 32'(if2.rd_data_o);    assign g_rd[3] = 32'(if3.rd_data_o);
  assign g_cyc[0] = if0.cycle_o;          assign g_cyc[1] = if1.cycle_o;
  assign g_cyc[2] = 32'(if2.cycle_o);     assign g_cyc[3] = 32'(if3.cycle_o);
  assign g_ovf[0] = if0.ovf_o;   assign g_ovf[1] = if1.ovf_o;
  assign g_ovf[2] = if2.ovf_o;   assign g_ovf[3] = if3.ovf_o;
  assign g_st[0] = if0.state_o;  assign g_st[1] = if1.state_o;
  assign g_st[2] = if2.state_o;  assign g_st[3] = if3.state_o;
  assign g_halt[0] = if0.halt_o; assign g_halt[1] = if1.halt_o;
  assign g_halt[2] = if2.halt_o; assign g_halt[3] = if3.halt_o;
  assign g_val[0] = if0.rd_valid_o; assign g_val[1] = if1.rd_valid_o;
  assign g_val[2] = if2.rd_valid_o; assign g_val[3] = if3.rd_valid_o;

  // ---------------- reference model ----------------
  int     cfg_w   [4] = '{32, 32, 4, 4};
  int     cfg_sat [4] = '{0, 0, 0, 1};
  int     cfg_lim [4] = '{0, 30, 0, 0};
  longint m_cnt  [4][5];   // index 4 is the cycle counter
  longint m_snap [4][5];
  bit [3:0] m_ovf[4];
  bit     m_run  [4];
  bit     m_halt [4];
  longint m_rd   [4];
  bit     m_val  [4];

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 5; j++) begin
        m_cnt[k][j]  = 0;
        m_snap[k][j] = 0;
      end
      m_ovf[k] = '0; m_run[k] = 0; m_halt[k] = 0; m_rd[k] = 0; m_val[k] = 0;
    end
  endfunction

  function automatic void model_step(int k);
    longint maxv = (longint'(1) << cfg_w[k]) - 1;
    int sel = int'(rd_sel);
    m_val[k] = rd_en;
    if (rd_en) m_rd[k] = (sel <= 4) ? (rd_snap ? m_snap[k][sel] : m_cnt[k][sel]) : 0;
    if (clear) begin
      for (int j = 0; j < 5; j++) begin
        m_cnt[k][j]  = 0;
        m_snap[k][j] = 0;
      end
      m_ovf[k] = '0; m_run[k] = 0; m_halt[k] = 0;
      return;
    end
    if (snap) for (int j = 0; j < 5; j++) m_snap[k][j] = m_cnt[k][j];
    if (start && !m_halt[k]) begin
      for (int j = 0; j < 5; j++) begin
        if (j == 4 || ev[j]) begin
          m_cnt[k][j] = m_cnt[k][j] + 1;
          if (m_cnt[k][j] > maxv) begin
            m_cnt[k][j] = (cfg_sat[k] != 0) ? maxv : 0;
            if (j < 4) m_ovf[k][j] = 1'b1;
          end
        end
      end
      if (cfg_lim[k] != 0 && m_cnt[k][4] == longint'(cfg_lim[k])) begin
        m_halt[k] = 1; m_run[k] = 0;
      end else begin
        m_run[k] = 1;
      end
    end else if (!m_halt[k]) begin
      m_run[k] = 0;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] est;
      est = m_halt[k] ? 2'd2 : (m_run[k] ? 2'd1 : 2'd0);
      chk($sformatf("dut%0d state", k), 64'(g_st[k]), 64'(est));
      chk($sformatf("dut%0d halt", k), 64'(g_halt[k]), 64'(m_halt[k]));
      chk($sformatf("dut%0d cycle", k), 64'(g_cyc[k]), m_cnt[k][4]);
      chk($sformatf("dut%0d ovf", k), 64'(g_ovf[k]), 64'(m_ovf[k]));
      chk($sformatf("dut%0d rd_valid", k), 64'(g_val[k]), 64'(m_val[k]));
      chk($sformatf("dut%0d rd_data", k), 64'(g_rd[k]), m_rd[k]);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 4; k++) model_step(k);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_in(input bit s, input bit [3:0] e, input bit sn, input bit c,
                        input bit re, input bit [2:0] sel, input bit rs);
    start = s; ev = e; snap = sn; clear = c; rd_en = re; rd_sel = sel; rd_snap = rs;
  endtask

  task automatic read(input bit [2:0] sel, input bit rs);
    set_in(0, 4'b0000, 0, 0, 1, sel, rs);
    tick();
  endtask

  // ---------------- basic-count vector table (dut0) ----------------
  typedef struct {
    bit       start;
    bit [3:0] ev;
    bit       rd_en;
    bit [2:0] sel;
    bit [1:0] st;
    longint   cyc;
    bit       val;
    longint   rd;
  } vec_t;

  vec_t vec[20];

  function automatic vec_t mk(bit s, bit [3:0] e, bit re, bit [2:0] sel,
                              bit [1:0] st, longint cyc, bit val, longint rd);
    vec_t v;
    v.start = s; v.ev = e; v.rd_en = re; v.sel = sel;
    v.st = st; v.cyc = cyc; v.val = val; v.rd = rd;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 10; i++)
      vec[i] = mk(1, (i == 0 || i == 3 || i == 6) ? 4'b0011 : 4'b0001, 0, 0, 2'd1, i + 1, 0, 0);
    for (int i = 10; i < 15; i++) vec[i] = mk(0, 4'b1111, 0, 0, 2'd0, 10, 0, 0);
    vec[15] = mk(0, 4'b0000, 1, 3'd0, 2'd0, 10, 1, 10);
    vec[16] = mk(0, 4'b0000, 1, 3'd1, 2'd0, 10, 1, 3);
    vec[17] = mk(0, 4'b0000, 1, 3'd4, 2'd0, 10, 1, 10);
    vec[18] = mk(0, 4'b0000, 1, 3'd7, 2'd0, 10, 1, 0);
    vec[19] = mk(0, 4'b0000, 0, 3'd0, 2'd0, 10, 0, 0);

    // reset values, visible while reset is held
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst dut%0d state", k), 64'(g_st[k]), 0);
      chk($sformatf("rst dut%0d cycle", k), 64'(g_cyc[k]), 0);
      chk($sformatf("rst dut%0d rd_data", k), 64'(g_rd[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(vec[i].start, vec[i].ev, 0, 0, vec[i].rd_en, vec[i].sel, 0);
      tick();
      chk($sformatf("vec%0d state", i), 64'(g_st[0]), 64'(vec[i].st));
      chk($sformatf("vec%0d cycle", i), 64'(g_cyc[0]), vec[i].cyc);
      chk($sformatf("vec%0d rd_valid", i), 64'(g_val[0]), 64'(vec[i].val));
      chk($sformatf("vec%0d rd_data", i), 64'(g_rd[0]), vec[i].rd);
    end

    // snapshot and read
    set_in(0, 4'b0000, 0, 1, 0, 0, 0); tick();
    set_in(1, 4'b0001, 0, 0, 0, 0, 0);
    repeat (7) tick();
    snap = 1; tick(); snap = 0;
    repeat (4) tick();
    set_in(0, 4'b0000, 0, 0, 0, 0, 0); tick();
    read(3'd0, 1);
    chk("snap ch0", 64'(g_rd[0]), 7);
    chk("snap valid", 64'(g_val[0]), 1);
    set_in(0, 4'b0000, 0, 0, 0, 0, 0); tick();
    chk("valid single pulse", 64'(g_val[0]), 0);
    chk("rd_data held", 64'(g_rd[0]), 7);
    read(3'd0, 0); chk("live ch0", 64'(g_rd[0]), 12);
    read(3'd4, 0); chk("live cycle", 64'(g_rd[0]), 12);
    read(3'd7, 0); chk("sel above range", 64'(g_rd[0]), 0);
    read(3'd4, 1); chk("snap cycle", 64'(g_rd[0]), 7);

    // clear, snap and events on one edge
    set_in(1, 4'b1111, 1, 1, 0, 0, 0); tick();
    chk("simul state", 64'(g_st[0]), 0);
    chk("simul cycle", 64'(g_cyc[0]), 0);
    chk("simul ovf", 64'(g_ovf[0]), 0);
    read(3'd0, 1); chk("simul snap ch0", 64'(g_rd[0]), 0);
    read(3'd0, 0); chk("simul live ch0", 64'(g_rd[0]), 0);
    read(3'd4, 1); chk("simul snap cycle", 64'(g_rd[0]), 0);

    // limit halt (dut1)
    set_in(1, 4'b1111, 0, 0, 0, 0, 0);
    repeat (29) tick();
    chk("limit pre halt", 64'(g_halt[1]), 0);
    chk("limit pre cycle", 64'(g_cyc[1]), 29);
    tick();
    chk("limit halt", 64'(g_halt[1]), 1);
    chk("limit cycle", 64'(g_cyc[1]), 30);
    chk("limit state", 64'(g_st[1]), 2);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      tick();
    end
    chk("halt frozen cycle", 64'(g_cyc[1]), 30);
    chk("halt frozen state", 64'(g_st[1]), 2);
    read(3'd0, 0); chk("halt ch0", 64'(g_rd[1]), 30);
    set_in(0, 4'b0000, 0, 1, 0, 0, 0); tick();
    chk("halt clear state", 64'(g_st[1]), 0);
    chk("halt clear cycle", 64'(g_cyc[1]), 0);
    read(3'd0, 0); chk("halt clear ch0", 64'(g_rd[1]), 0);

    // overflow on 4-bit counters
    set_in(0, 4'b0000, 0, 1, 0, 0, 0); tick();
    set_in(1, 4'b0100, 0, 0, 0, 0, 0);
    repeat (17) tick();
    read(3'd2, 0);
    chk("wrap ch2", 64'(g_rd[2]), 1);
    chk("wrap ovf", 64'(g_ovf[2]), 4);
    chk("sat ch2", 64'(g_rd[3]), 15);
    chk("sat ovf", 64'(g_ovf[3]), 4);
    chk("wrap ovf0", 64'(g_ovf[2][0]), 0);
    chk("sat ovf0", 64'(g_ovf[3][0]), 0);

    // async reset mid-run
    set_in(1, 4'b1111, 0, 0, 0, 0, 0);
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arst dut%0d state", k), 64'(g_st[k]), 0);
      chk($sformatf("arst dut%0d cycle", k), 64'(g_cyc[k]), 0);
      chk($sformatf("arst dut%0d ovf", k), 64'(g_ovf[k]), 0);
      chk($sformatf("arst dut%0d halt", k), 64'(g_halt[k]), 0);
    end
    model_reset();
    #1;
    rst = 1'b0;
    set_in(1, 4'b0001, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("resume cycle", 64'(g_cyc[0]), 3);
    read(3'd0, 0); chk("resume ch0", 64'(g_rd[0]), 3);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 9) > 1, 4'($urandom_range(0, 15)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
